// File: rtl/call_stack.sv
// call_stack: parametrised LIFO for CALL return addresses and PUSH/POP data.
// Latency: an operation is visible on the outputs the cycle after its clock edge.
// Backpressure: none; a push on a full stack sets OVF and a pop on an empty stack sets UDF.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   PUSH, POP, ERR_CLR  commands (PUSH+POP on a non-empty stack replaces the top entry)
//   DATA_IN             value to push
//   DATA_OUT            top of stack, 0 when empty
//   COUNT, EMPTY, FULL  occupancy status
//   OVF, UDF            sticky overflow / underflow flags
//
// Build option: define CALL_STACK_WRAP_EN so that a push on a full stack
// overwrites the oldest entry instead of being dropped.
module call_stack #(
    parameter int DATA_WIDTH = 8,
    parameter int PTR_WIDTH  = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  PUSH,
    input  logic                  POP,
    input  logic                  ERR_CLR,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    output logic [DATA_WIDTH-1:0] DATA_OUT,
    output logic [PTR_WIDTH:0]    COUNT,
    output logic                  EMPTY,
    output logic                  FULL,
    output logic                  OVF,
    output logic                  UDF
);
    localparam int DEPTH = 2 ** PTR_WIDTH;

    localparam logic [PTR_WIDTH:0]   CNT_ONE  = 1;
    localparam logic [PTR_WIDTH:0]   CNT_FULL = {1'b1, {PTR_WIDTH{1'b0}}};
    localparam logic [PTR_WIDTH-1:0] PTR_ONE  = 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_WIDTH-1:0] base_q, base_d;
    logic [PTR_WIDTH:0]   count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic                 udf_q, udf_d;

    logic                 empty, full;
    logic [PTR_WIDTH-1:0] top_idx, push_idx, wr_idx;
    logic                 wr_en;
    logic                 ovf_ev, udf_ev;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_FULL);

    // When full, the low count bits are zero, so top = base - 1 mod DEPTH,
    // which is the newest entry sitting just behind the oldest one.
    assign top_idx  = base_q + count_q[PTR_WIDTH-1:0] - PTR_ONE;
    assign push_idx = base_q + count_q[PTR_WIDTH-1:0];

    always_comb begin
        base_d  = base_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_idx  = top_idx;
        ovf_ev  = 1'b0;
        udf_ev  = 1'b0;

        if (PUSH && POP && !empty) begin
            // Replace top: count and flags untouched.
            wr_en  = 1'b1;
            wr_idx = top_idx;
        end else if (PUSH) begin
            // PUSH alone, or PUSH+POP on an empty stack (no underflow then).
            if (!full) begin
                wr_en   = 1'b1;
                wr_idx  = push_idx;
                count_d = count_q + CNT_ONE;
            end else begin
                ovf_ev = 1'b1;
`ifdef CALL_STACK_WRAP_EN
                // The slot after top is the oldest entry; overwrite it and
                // advance base so the new value becomes top.
                wr_en  = 1'b1;
                wr_idx = base_q;
                base_d = base_q + PTR_ONE;
`endif
            end
        end else if (POP) begin
            if (!empty) begin
                count_d = count_q - CNT_ONE;
            end else begin
                udf_ev = 1'b1;
            end
        end

        // A new event in the same cycle as ERR_CLR keeps the flag set.
        ovf_d = ovf_ev | (ovf_q & ~ERR_CLR);
        udf_d = udf_ev | (udf_q & ~ERR_CLR);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            base_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            base_q  <= base_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Array contents survive reset; only the pointers are cleared.
    always_ff @(posedge CLK) begin
        if (!RST && wr_en) begin
            mem_q[wr_idx] <= DATA_IN;
        end
    end

    assign DATA_OUT = empty ? '0 : mem_q[top_idx];
    assign COUNT    = count_q;
    assign EMPTY    = empty;
    assign FULL     = full;
    assign OVF      = ovf_q;
    assign UDF      = udf_q;
endmodule

// File: tb/tb_call_stack.sv
// tb_call_stack: scoreboard bench for call_stack, 8x8 and 16x16 instances in lockstep.
// Latency: expected state is queued one edge after each command and compared on the following falling edge.
// Backpressure: none; the monitor compares whenever an expectation is queued.
module tb_call_stack;
    logic        clk = 1'b0;
    logic        rst, push, pop, clr;
    logic [7:0]  din8;
    logic [15:0] din16;

    logic [7:0]  dout8;
    logic [3:0]  cnt8;
    logic        emp8, ful8, ovf8, udf8;
    logic [15:0] dout16;
    logic [4:0]  cnt16;
    logic        emp16, ful16, ovf16, udf16;

    always #5 clk = ~clk;

    call_stack #(.DATA_WIDTH(8), .PTR_WIDTH(3)) u_dut8 (
        .CLK(clk), .RST(rst), .PUSH(push), .POP(pop), .ERR_CLR(clr),
        .DATA_IN(din8), .DATA_OUT(dout8), .COUNT(cnt8), .EMPTY(emp8),
        .FULL(ful8), .OVF(ovf8), .UDF(udf8)
    );

    call_stack #(.DATA_WIDTH(16), .PTR_WIDTH(4)) u_dut16 (
        .CLK(clk), .RST(rst), .PUSH(push), .POP(pop), .ERR_CLR(clr),
        .DATA_IN(din16), .DATA_OUT(dout16), .COUNT(cnt16), .EMPTY(emp16),
        .FULL(ful16), .OVF(ovf16), .UDF(udf16)
    );

    typedef struct {
        int unsigned dout [2];
        int unsigned cnt  [2];
        bit          emp  [2];
        bit          ful  [2];
        bit          ovf  [2];
        bit          udf  [2];
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: per instance an ordered list, index 0 = oldest entry.
    int unsigned st  [2][16];
    int          n   [2];
    bit          m_ovf [2];
    bit          m_udf [2];

    task automatic chk(input string name, input int unsigned act, input int unsigned expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit pu, input bit po, input bit cl, input int unsigned d);
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            int depth;
            int unsigned dm;
            bit oe, ue;
            depth = (k == 0) ? 8 : 16;
            dm    = (k == 0) ? (d & 32'hFF) : (d & 32'hFFFF);
            oe = 1'b0;
            ue = 1'b0;
            if (r) begin
                n[k] = 0;
                m_ovf[k] = 1'b0;
                m_udf[k] = 1'b0;
            end else begin
                if (pu && po && n[k] > 0) begin
                    st[k][n[k]-1] = dm;
                end else if (pu) begin
                    if (n[k] < depth) begin
                        st[k][n[k]] = dm;
                        n[k]++;
                    end else begin
                        oe = 1'b1;
`ifdef CALL_STACK_WRAP_EN
                        for (int i = 0; i < depth - 1; i++) st[k][i] = st[k][i+1];
                        st[k][depth-1] = dm;
`endif
                    end
                end else if (po) begin
                    if (n[k] > 0) n[k]--;
                    else ue = 1'b1;
                end
                m_ovf[k] = oe | (m_ovf[k] & !cl);
                m_udf[k] = ue | (m_udf[k] & !cl);
            end
            e.dout[k] = (n[k] == 0) ? 0 : st[k][n[k]-1];
            e.cnt[k]  = n[k];
            e.emp[k]  = (n[k] == 0);
            e.ful[k]  = (n[k] == depth);
            e.ovf[k]  = m_ovf[k];
            e.udf[k]  = m_udf[k];
        end
        exp_q.push_back(e);
    endtask

    task automatic step(input bit r, input bit pu, input bit po, input bit cl, input int unsigned d);
        @(negedge clk);
        rst   = r;
        push  = pu;
        pop   = po;
        clr   = cl;
        din8  = d[7:0];
        din16 = d[15:0];
        @(posedge clk);
        #1;
        model_step(r, pu, po, cl, d);
    endtask

    // Monitor: outputs are always presented, so compare whenever an expectation is pending.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("dout8",  32'(dout8),  e.dout[0]);
            chk("count8", 32'(cnt8),   e.cnt[0]);
            chk("empty8", 32'(emp8),   32'(e.emp[0]));
            chk("full8",  32'(ful8),   32'(e.ful[0]));
            chk("ovf8",   32'(ovf8),   32'(e.ovf[0]));
            chk("udf8",   32'(udf8),   32'(e.udf[0]));
            chk("dout16", 32'(dout16), e.dout[1]);
            chk("count16",32'(cnt16),  e.cnt[1]);
            chk("empty16",32'(emp16),  32'(e.emp[1]));
            chk("full16", 32'(ful16),  32'(e.ful[1]));
            chk("ovf16",  32'(ovf16),  32'(e.ovf[1]));
            chk("udf16",  32'(udf16),  32'(e.udf[1]));
        end
    end

    initial begin
        rst = 1'b0; push = 1'b0; pop = 1'b0; clr = 1'b0; din8 = '0; din16 = '0;
        for (int k = 0; k < 2; k++) begin
            n[k] = 0; m_ovf[k] = 1'b0; m_udf[k] = 1'b0;
        end

        // Reset state.
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Basic push / pop ordering.
        step(0, 1, 0, 0, 32'h11);
        step(0, 1, 0, 0, 32'h22);
        step(0, 1, 0, 0, 32'h33);
        repeat (3) step(0, 0, 1, 0, 0);

        // Underflow, clear, and set-wins-over-clear.
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 0);

        // Fill, overflow push, drain.
        for (int i = 1; i <= 8; i++) step(0, 1, 0, 0, 32'(i));
        step(0, 1, 0, 0, 32'h09);
        repeat (8) step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);

        // Replace top, and push+pop on empty.
        step(0, 1, 0, 0, 32'hA0);
        step(0, 1, 0, 0, 32'hB0);
        step(0, 1, 1, 0, 32'hC0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 1, 1, 0, 32'h5A);
        step(0, 0, 1, 0, 0);

        // Reset with a simultaneous push discards everything.
        step(0, 1, 0, 0, 32'h01);
        step(0, 1, 0, 0, 32'h02);
        step(0, 1, 0, 0, 32'h03);
        step(1, 1, 0, 0, 32'h04);

        // Deep instance: 16 pushes then one more; full replace; full drain.
        for (int i = 0; i < 17; i++) step(0, 1, 0, 0, 32'h1000 + 32'(i) * 32'h0111);
        step(0, 1, 1, 0, 32'hBEEF);
        repeat (17) step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);

        // Random traffic, back-to-back with occasional reset and error clear.
        for (int i = 0; i < 800; i++) begin
            bit r, pu, po, cl;
            int unsigned sel;
            sel = $urandom_range(0, 99);
            r   = ($urandom_range(0, 59) == 0);
            // Bias the mix over phases so the stack spends time both near full and near empty.
            if (i % 200 < 100) begin
                pu = (sel < 60);
                po = (sel >= 45 && sel < 80);
            end else begin
                pu = (sel < 35);
                po = (sel >= 25 && sel < 80);
            end
            cl = ($urandom_range(0, 7) == 0);
            step(r, pu, po, cl, $urandom);
        end
        step(0, 0, 0, 0, 0);

        // Drain the scoreboard with a bounded wait.
        for (int t = 0; t < 5 && exp_q.size() > 0; t++) @(negedge clk);
        @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d pending expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
